// File: rtl/video_write_arbiter.sv
// rtl/video_write_arbiter.sv - round-robin arbiter for the video memory write port
// Locked bursts, blackout stall, registered write strobe/data, one-cycle ack per write.
module video_write_arbiter #(
    parameter int NREQ      = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 24,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   req_address,
    input  logic [NREQ*DATA_W-1:0]   req_value,
    input  logic [NREQ*DATA_W-1:0]   req_mask,
    input  logic                     blackout,
    output logic [NREQ-1:0]          ack,
    output logic                     video_write,
    output logic [ADDR_W-1:0]        video_address,
    output logic [DATA_W-1:0]        video_value,
    output logic [DATA_W-1:0]        video_mask,
    output logic [1:0]               grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    state_t      state, state_next;
    logic [1:0]  ptr;
    logic [7:0]  count;
    logic [1:0]  winner;
    logic        winner_valid;
    logic [1:0]  sel;
    logic        issue;

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] value_arr [NREQ];
    logic [DATA_W-1:0] mask_arr  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_address[i*ADDR_W +: ADDR_W];
            value_arr[i] = req_value[i*DATA_W +: DATA_W];
            mask_arr[i]  = req_mask[i*DATA_W +: DATA_W];
        end
    end

    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] cand;
        winner       = '0;
        winner_valid = 1'b0;
        sum          = '0;
        cand         = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(NREQ))
                sum = sum - 3'(NREQ);
            cand = sum[1:0];
            if (req[cand]) begin
                winner       = cand;
                winner_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        sel        = grant_id;
        case (state)
            IDLE: begin
                if (!blackout && winner_valid) begin
                    issue      = 1'b1;
                    sel        = winner;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (lock[grant_id] && req[grant_id] && count < 8'(MAX_BURST))
                    state_next = HOLD;
                else
                    state_next = IDLE;
            end
            HOLD: begin
                if (!req[grant_id] || !lock[grant_id]) begin
                    state_next = IDLE;
                end else if (!blackout) begin
                    issue      = 1'b1;
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 2'(NREQ - 1);
            count         <= '0;
            ack           <= '0;
            video_write   <= 1'b0;
            video_address <= '0;
            video_value   <= '0;
            video_mask    <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != IDLE);
            video_write <= issue;
            ack         <= issue ? ({{(NREQ-1){1'b0}}, 1'b1} << sel) : '0;
            if (issue) begin
                video_address <= addr_arr[sel];
                video_value   <= value_arr[sel];
                video_mask    <= mask_arr[sel];
                grant_id      <= sel;
                // A fresh grant moves the pointer; burst continuations keep it.
                if (state == IDLE) begin
                    ptr   <= sel;
                    count <= 8'd1;
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_write_arbiter.sv
// tb/tb_video_write_arbiter.sv - bench for video_write_arbiter
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_video_write_arbiter;

    localparam int NREQ = 3, ADDR_W = 16, DATA_W = 24, MAX_BURST = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req, lock;
    logic [NREQ*ADDR_W-1:0] req_address;
    logic [NREQ*DATA_W-1:0] req_value, req_mask;
    logic                   blackout;
    logic [NREQ-1:0]        ack;
    logic                   video_write;
    logic [ADDR_W-1:0]      video_address;
    logic [DATA_W-1:0]      video_value, video_mask;
    logic [1:0]             grant_id;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic                   m_write, m_busy;
    logic [NREQ-1:0]        m_ack;
    logic [ADDR_W-1:0]      m_addr;
    logic [DATA_W-1:0]      m_val, m_mask;
    int                     m_gid, m_ptr, m_count;
    bit                     m_tenure, m_wrote;

    video_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .req_address(req_address), .req_value(req_value), .req_mask(req_mask),
        .blackout(blackout), .ack(ack), .video_write(video_write),
        .video_address(video_address), .video_value(video_value), .video_mask(video_mask),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_issue(input int w);
        m_write = 1'b1;
        m_ack   = NREQ'(1) << w;
        m_gid   = w;
        m_busy  = 1'b1;
        m_wrote = 1'b1;
        m_addr  = req_address[w*ADDR_W +: ADDR_W];
        m_val   = req_value[w*DATA_W +: DATA_W];
        m_mask  = req_mask[w*DATA_W +: DATA_W];
    endtask

    // Advance the model by one edge using the inputs currently driven, then clock the DUT.
    task automatic tick();
        int w;
        if (reset) begin
            m_write = 0; m_ack = '0; m_addr = '0; m_val = '0; m_mask = '0;
            m_gid = 0; m_busy = 0; m_ptr = NREQ - 1; m_count = 0;
            m_tenure = 0; m_wrote = 0;
        end else begin
            m_write = 0;
            m_ack   = '0;
            if (m_wrote) begin
                m_wrote  = 0;
                m_tenure = lock[m_gid] && req[m_gid] && (m_count < MAX_BURST);
                m_busy   = m_tenure;
            end else if (m_tenure) begin
                if (!req[m_gid] || !lock[m_gid]) begin
                    m_tenure = 0;
                    m_busy   = 0;
                end else if (!blackout) begin
                    m_count++;
                    model_issue(m_gid);
                end
            end else if (!blackout && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                m_ptr   = w;
                m_count = 1;
                model_issue(w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; req = '0; lock = '0; blackout = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({video_write, ack, grant_id, busy, video_address, video_value, video_mask} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs actual wr=%b ack=%b gid=%0d busy=%b addr=%h required all zero",
                     video_write, ack, grant_id, busy, video_address);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_address[0 +: ADDR_W] = 16'h0010;
        req_value[0 +: DATA_W]   = 24'h123456;
        req_mask[0 +: DATA_W]    = 24'hFFFFFF;
        req = 3'b001;
        tick();
        req = 3'b000;
        n_checks++;
        if ({video_write, ack, grant_id, busy} !== {1'b1, 3'b001, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_ctrl actual wr=%b ack=%b gid=%0d busy=%b required 1 001 0 1",
                     video_write, ack, grant_id, busy);
        end
        n_checks++;
        if ({video_address, video_value, video_mask} !== {16'h0010, 24'h123456, 24'hFFFFFF}) begin
            n_fail++;
            $display("FAIL single_data actual %h %h %h required 0010 123456 ffffff",
                     video_address, video_value, video_mask);
        end
        tick();
        n_checks++;
        if ({video_write, ack, video_address} !== {1'b0, 3'b000, 16'h0010}) begin
            n_fail++;
            $display("FAIL single_after actual wr=%b ack=%b addr=%h required 0 000 0010",
                     video_write, ack, video_address);
        end
    endtask

    task automatic test_contention();
        int exp_owner [5] = '{0, 1, 2, 0, 1};
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (video_write !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL contention_strobe cycle %0d actual %b required %b", i, video_write, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                n_checks++;
                if (grant_id !== 2'(exp_owner[i/2]) || ack !== (NREQ'(1) << exp_owner[i/2])) begin
                    n_fail++;
                    $display("FAIL contention_owner write %0d actual gid=%0d ack=%b required %0d",
                             i/2, grant_id, ack, exp_owner[i/2]);
                end
            end
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_burst();
        int exp_o;
        do_reset();
        lock = 3'b010;
        req  = 3'b011;
        for (int i = 1; i <= 19; i++) begin
            tick();
            exp_o = (i == 1 || i == 19) ? 0 : 1;
            n_checks++;
            if (video_write !== (i % 2 == 1) || (video_write && grant_id !== 2'(exp_o))) begin
                n_fail++;
                $display("FAIL burst_seq cycle %0d actual wr=%b gid=%0d required wr=%b gid=%0d",
                         i, video_write, grant_id, (i % 2 == 1), exp_o);
            end
            if (i >= 4 && i <= 16 && i % 2 == 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL burst_hold_busy cycle %0d actual %b required 1", i, busy);
                end
            end
        end
        req = '0; lock = '0;
        tick(); tick();
    endtask

    task automatic test_blackout();
        int seen = 0;
        do_reset();
        blackout = 1;
        req = 3'b100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (video_write || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL blackout_stall actual %0d active cycles required 0", seen);
        end
        blackout = 0;
        tick();
        req = '0;
        n_checks++;
        if ({video_write, ack, grant_id} !== {1'b1, 3'b100, 2'd2}) begin
            n_fail++;
            $display("FAIL blackout_release actual wr=%b ack=%b gid=%0d required 1 100 2",
                     video_write, ack, grant_id);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req = 3'b001;
        tick();
        reset = 1;
        tick();
        n_checks++;
        if ({video_write, ack, grant_id, busy, video_address, video_value, video_mask} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_write actual wr=%b ack=%b gid=%0d busy=%b required all zero",
                     video_write, ack, grant_id, busy);
        end
        reset = 0;
        req = 3'b011;
        tick();
        req = '0;
        n_checks++;
        if ({video_write, ack, grant_id} !== {1'b1, 3'b001, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_regrant actual wr=%b ack=%b gid=%0d required 1 001 0",
                     video_write, ack, grant_id);
        end
        tick();
    endtask

    task automatic test_burst_abort();
        do_reset();
        lock = 3'b100;
        req  = 3'b100;
        tick();
        tick();
        n_checks++;
        if ({video_write, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_hold actual wr=%b busy=%b required 0 1", video_write, busy);
        end
        req = 3'b001;
        tick();
        n_checks++;
        if ({video_write, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle actual wr=%b busy=%b required 0 0", video_write, busy);
        end
        tick();
        req = '0;
        n_checks++;
        if ({video_write, ack, grant_id} !== {1'b1, 3'b001, 2'd0}) begin
            n_fail++;
            $display("FAIL abort_next actual wr=%b ack=%b gid=%0d required 1 001 0",
                     video_write, ack, grant_id);
        end
        lock = '0;
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                req_address[r*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                req_value[r*DATA_W +: DATA_W]   = DATA_W'($urandom);
                req_mask[r*DATA_W +: DATA_W]    = DATA_W'($urandom);
            end
            req      = NREQ'($urandom);
            lock     = ($urandom_range(0, 3) != 0) ? NREQ'($urandom) : '0;
            blackout = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if ({video_write, ack, grant_id, busy, video_address, video_value, video_mask} !==
                {m_write, m_ack, 2'(m_gid), m_busy, m_addr, m_val, m_mask} ||
                $countones(ack) > 1 || (ack != '0 && !video_write)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d actual wr=%b ack=%b gid=%0d busy=%b addr=%h required wr=%b ack=%b gid=%0d busy=%b addr=%h",
                             i, video_write, ack, grant_id, busy, video_address,
                             m_write, m_ack, m_gid, m_busy, m_addr);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; req = '0; lock = '0; blackout = 0;
        req_address = '0; req_value = '0; req_mask = '0;
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_blackout();
        test_reset_mid_write();
        test_burst_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
